// File: rtl/pickup_pkg.sv
// Shared state encodings and arm-position codes for the pickup sequencer.
package pickup_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRIVE    = 3'd1,
    SETTLE   = 3'd2,
    LOWER    = 3'd3,
    GRAB     = 3'd4,
    RAISE    = 3'd5,
    COOLDOWN = 3'd6
  } state_t;

  localparam logic ARM_UP   = 1'b0;
  localparam logic ARM_DOWN = 1'b1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servo_pwm.sv
// Free-running servo PWM; the pulse width is re-latched only at the start of each period.
module servo_pwm #(
  parameter int unsigned PERIOD = 1_000_000,
  parameter int unsigned W_UP   = 50_000,
  parameter int unsigned W_DOWN = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic width_sel,
  output logic pwm_out
);
  import pickup_pkg::*;

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] wid, wid_n;

  always_comb begin
    cnt_n = (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
    wid_n = wid;
    if (cnt_n == '0) begin
      wid_n = (width_sel == ARM_DOWN) ? CW'(W_DOWN) : CW'(W_UP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      wid     <= CW'(W_UP);
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      wid     <= wid_n;
      pwm_out <= (cnt_n < wid_n);
    end
  end

endmodule

// File: rtl/pickup_sequencer.sv
// Pickup sequencer: debounced colour trigger, stop/lower/grab/raise arm sequence, cooldown.
module pickup_sequencer #(
  parameter int unsigned DEB_CYC    = 50_000,
  parameter int unsigned SETTLE_CYC = 25_000_000,
  parameter int unsigned ARM_CYC    = 25_000_000,
  parameter int unsigned GRAB_CYC   = 12_500_000,
  parameter int unsigned COOL_CYC   = 50_000_000,
  parameter int unsigned PWM_PERIOD = 1_000_000,
  parameter int unsigned SERVO_UP   = 50_000,
  parameter int unsigned SERVO_DOWN = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ir_state,
  output logic       motor_en,
  output logic       magnet_en,
  output logic       servo_pwm,
  output logic       busy,
  output logic [3:0] pick_count,
  output logic [2:0] state_dbg
);
  import pickup_pkg::*;

  localparam int unsigned MAXC = max2(max2(max2(DEB_CYC, SETTLE_CYC), max2(ARM_CYC, GRAB_CYC)),
                                      COOL_CYC);
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] deb;
  logic          stop_lat;
  logic          arm_dn;
  logic          run, col;

  assign run       = ir_state[1];
  assign col       = ir_state[0];
  assign state_dbg = 3'(state);

  // Next-state selection; once the arm has started down, a stop always finishes RAISE first.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (run) state_n = DRIVE;
      DRIVE: begin
        if (!run)                                      state_n = IDLE;
        else if (col && (deb == TW'(DEB_CYC - 1)))     state_n = SETTLE;
      end
      SETTLE: begin
        if (!run)                                      state_n = IDLE;
        else if (timer == TW'(SETTLE_CYC - 1))         state_n = LOWER;
      end
      LOWER: begin
        if (!run)                                      state_n = RAISE;
        else if (timer == TW'(ARM_CYC - 1))            state_n = GRAB;
      end
      GRAB: begin
        if (!run)                                      state_n = RAISE;
        else if (timer == TW'(GRAB_CYC - 1))           state_n = RAISE;
      end
      RAISE: begin
        if (timer == TW'(ARM_CYC - 1))
          state_n = (stop_lat || !run) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (!run)                                      state_n = IDLE;
        else if (timer == TW'(COOL_CYC - 1))           state_n = DRIVE;
      end
      default:                                         state_n = IDLE;
    endcase
  end

  // State, counters and outputs registered from the next state so outputs track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      deb        <= '0;
      stop_lat   <= 1'b0;
      pick_count <= 4'd0;
      motor_en   <= 1'b0;
      magnet_en  <= 1'b0;
      busy       <= 1'b0;
      arm_dn     <= ARM_UP;
    end else begin
      state <= state_n;
      timer <= ((state_n != state) || (state_n == IDLE) || (state_n == DRIVE))
               ? '0 : timer + TW'(1);
      deb   <= ((state == DRIVE) && (state_n == DRIVE) && col) ? deb + TW'(1) : '0;

      if (state == IDLE)
        stop_lat <= 1'b0;
      else if (!run && ((state == LOWER) || (state == GRAB) || (state == RAISE)))
        stop_lat <= 1'b1;

      if ((state == RAISE) && (state_n == COOLDOWN) && (pick_count != 4'd15))
        pick_count <= pick_count + 4'd1;

      if (state_n == GRAB)
        magnet_en <= 1'b1;
      else if (state_n == IDLE)
        magnet_en <= 1'b0;

      motor_en <= (state_n == DRIVE) || (state_n == COOLDOWN);
      busy     <= state_n inside {SETTLE, LOWER, GRAB, RAISE};
      arm_dn   <= ((state_n == LOWER) || (state_n == GRAB)) ? ARM_DOWN : ARM_UP;
    end
  end

  servo_pwm #(
    .PERIOD (PWM_PERIOD),
    .W_UP   (SERVO_UP),
    .W_DOWN (SERVO_DOWN)
  ) u_servo (
    .clk       (clk),
    .rst       (rst),
    .width_sel (arm_dn),
    .pwm_out   (servo_pwm)
  );

endmodule

// File: tb/tb_pickup_sequencer.sv
// Bench for pickup_sequencer: directed scenarios plus random run/colour traffic against a cycle model.
module tb_pickup_sequencer;

  localparam int DEB = 4, SET = 8, ARM = 16, GRB = 8, COOL = 32, P = 100, UP = 5, DN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ir_state = 2'b00;
  logic       motor_en, magnet_en, servo_pwm, busy;
  logic [3:0] pick_count;
  logic [2:0] state_dbg;

  pickup_sequencer #(
    .DEB_CYC(DEB), .SETTLE_CYC(SET), .ARM_CYC(ARM), .GRAB_CYC(GRB), .COOL_CYC(COOL),
    .PWM_PERIOD(P), .SERVO_UP(UP), .SERVO_DOWN(DN)
  ) dut (
    .clk(clk), .rst(rst), .ir_state(ir_state), .motor_en(motor_en), .magnet_en(magnet_en),
    .servo_pwm(servo_pwm), .busy(busy), .pick_count(pick_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, cycles spent in it, colour run length, pwm period bookkeeping.
  int   m_st = 0, m_held = 0, m_run = 0, m_picks = 0, m_k = 0, m_w = UP;
  logic m_stop = 1'b0, m_mag = 1'b0, m_arm_prev = 1'b0, m_pwm = 1'b0;

  task automatic m_reset();
    m_st = 0; m_held = 0; m_run = 0; m_picks = 0; m_k = 0; m_w = UP;
    m_stop = 1'b0; m_mag = 1'b0; m_arm_prev = 1'b0; m_pwm = 1'b0;
  endtask

  task automatic m_step(input logic run, input logic col);
    int nst;
    nst = m_st;
    m_held++;
    case (m_st)
      0: if (run) nst = 1;
      1: begin
        if (!run) nst = 0;
        else if (col) begin
          m_run++;
          if (m_run == DEB) nst = 2;
        end else m_run = 0;
      end
      2: if (!run) nst = 0; else if (m_held == SET) nst = 3;
      3: if (!run) begin m_stop = 1'b1; nst = 5; end else if (m_held == ARM) nst = 4;
      4: if (!run) begin m_stop = 1'b1; nst = 5; end else if (m_held == GRB) nst = 5;
      5: begin
        if (!run) m_stop = 1'b1;
        if (m_held == ARM) begin
          if (m_stop) nst = 0;
          else begin
            nst = 6;
            if (m_picks < 15) m_picks++;
          end
        end
      end
      6: if (!run) nst = 0; else if (m_held == COOL) nst = 1;
      default: nst = 0;
    endcase
    if (nst != m_st) begin m_held = 0; m_run = 0; end
    if (nst == 4) m_mag = 1'b1;
    if (nst == 0) begin m_mag = 1'b0; m_stop = 1'b0; end
    m_st = nst;
    m_k++;
    if (m_k % P == 0) m_w = m_arm_prev ? DN : UP;
    m_pwm = (m_k % P) < m_w;
    m_arm_prev = (m_st == 3) || (m_st == 4);
  endtask

  // Model advance and per-cycle comparison.
  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else begin
      m_step(ir_state[1], ir_state[0]);
      #1;
      chk("state",  int'(state_dbg),  m_st);
      chk("motor",  int'(motor_en),   int'(m_st == 1 || m_st == 6));
      chk("busy",   int'(busy),       int'(m_st >= 2 && m_st <= 5));
      chk("magnet", int'(magnet_en),  int'(m_mag));
      chk("picks",  int'(pick_count), m_picks);
      chk("pwm",    int'(servo_pwm),  int'(m_pwm));
    end
  end

  int meas_p = -10;
  int hi_a = 0, hi_b = 0;

  task automatic cyc(input logic run, input logic col);
    @(negedge clk);
    ir_state = {run, col};
    @(posedge clk);
    #1;
    if (servo_pwm) begin
      if (m_k / P == meas_p) hi_a++;
      else if (m_k / P == meas_p + 1) hi_b++;
    end
  endtask

  task automatic measure(input int st, input int expn, input string nm, input logic run);
    int n;
    n = 1;
    while (int'(state_dbg) == st && n < 1000) begin
      cyc(run, 1'b1);
      if (int'(state_dbg) == st) n++;
    end
    chk(nm, n, expn);
  endtask

  task automatic go_to(input int st, input string nm);
    int n;
    n = 0;
    while (int'(state_dbg) != st && n < 2000) begin
      cyc(1'b1, 1'b1);
      n++;
    end
    chk(nm, int'(state_dbg), st);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_state"},  int'(state_dbg),  0);
    chk({nm, "_motor"},  int'(motor_en),   0);
    chk({nm, "_magnet"}, int'(magnet_en),  0);
    chk({nm, "_busy"},   int'(busy),       0);
    chk({nm, "_picks"},  int'(pick_count), 0);
    chk({nm, "_pwm"},    int'(servo_pwm),  0);
  endtask

  initial begin
    logic pat [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int   n;

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    // Debounce: broken run of highs must not trigger early.
    cyc(1'b1, 1'b0);
    chk("drive_entry", int'(state_dbg), 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, pat[i]);
    chk("deb_no_early", int'(state_dbg), 1);
    cyc(1'b1, 1'b1);
    chk("deb_settle", int'(state_dbg), 2);

    // Full pickup with exact phase lengths.
    measure(2, SET, "settle_len", 1'b1);
    chk("lower_entry", int'(state_dbg), 3);
    chk("lower_magnet", int'(magnet_en), 0);
    measure(3, ARM, "lower_len", 1'b1);
    chk("grab_entry", int'(state_dbg), 4);
    chk("grab_magnet", int'(magnet_en), 1);
    measure(4, GRB, "grab_len", 1'b1);
    chk("raise_entry", int'(state_dbg), 5);
    chk("raise_picks", int'(pick_count), 0);
    measure(5, ARM, "raise_len", 1'b1);
    chk("cool_entry", int'(state_dbg), 6);
    chk("cool_picks", int'(pick_count), 1);
    measure(6, COOL, "cool_len", 1'b1);
    chk("drive_resume", int'(state_dbg), 1);
    chk("drive_magnet", int'(magnet_en), 1);
    measure(1, DEB, "redebounce_len", 1'b1);

    // Stop during GRAB cycle 3.
    go_to(4, "goto_grab");
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("stop_to_raise", int'(state_dbg), 5);
    measure(5, ARM, "stop_raise_len", 1'b0);
    chk("stop_idle", int'(state_dbg), 0);
    chk("stop_picks", int'(pick_count), 1);
    chk("stop_magnet", int'(magnet_en), 0);

    // PWM: arm goes down mid-period, widens only from the next period.
    n = 0;
    while ((m_k % P) != P - 1 && n < 300) begin cyc(1'b0, 1'b0); n++; end
    chk("pwm_align", m_k % P, P - 1);
    meas_p = m_k / P + 1;
    hi_a = 0; hi_b = 0;
    repeat (80) cyc(1'b0, 1'b0);
    repeat (220) cyc(1'b1, 1'b1);
    chk("pwm_up_pulse", hi_a, UP);
    chk("pwm_down_pulse", hi_b, DN);

    // Random run/colour traffic with varying stop density.
    for (int s = 0; s < 20; s++) begin
      int rate;
      rate = $urandom_range(20, 400);
      repeat (200) cyc(($urandom % rate) != 0, ($urandom % 4) != 0);
    end

    // Saturation with colour held through every cooldown.
    repeat (1800) cyc(1'b1, 1'b1);
    chk("pick_sat", int'(pick_count), 15);

    // Async reset mid-GRAB, effective without a clock edge.
    go_to(4, "goto_grab_rst");
    cyc(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst = 1'b0;
    ir_state = 2'b00;
    repeat (5) cyc(1'b1, 1'b0);
    chk("post_rst_drive", int'(state_dbg), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
